// File: rtl/uncache.sv
// uncache: expands densely packed capture words back into per-channel-group samples.
// Defining UNCACHE_FLUSH_EN adds flush_i, which emits a trailing partial sample on request.
module uncache #(
  parameter int INPUT  = 4,
  parameter int OUTPUT = 4
) (
  input  logic                clk_i,
  input  logic                rst_in,
  input  logic                cfg_stb_i,
  input  logic [OUTPUT-1:0]   cfg_i,
  input  logic                stb_i,
  input  logic [INPUT*8-1:0]  d_i,
  output logic                rdy_o,
  output logic                stb_o,
  output logic [OUTPUT*8-1:0] q_o,
`ifdef UNCACHE_FLUSH_EN
  input  logic                flush_i,
`endif
  input  logic                ack_i
);

  localparam int BUF = INPUT + OUTPUT - 1;
  localparam int CW  = $clog2(BUF + 1);
  localparam int BW  = (BUF > 1) ? $clog2(BUF) : 1;
  localparam int DW  = (INPUT > 1) ? $clog2(INPUT) : 1;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t              state_q, state_d;
  logic [7:0]          buf_q [BUF];
  logic [7:0]          buf_d [BUF];
  logic [7:0]          d_bytes [INPUT];
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [OUTPUT-1:0]   cfg_q, cfg_d, en;
  logic [OUTPUT*8-1:0] q_q, q_d;
  logic                alive_q, push, load;
  int                  n, cnt, pop, avail, k, idx;

  for (genvar b = 0; b < INPUT; b++) begin : gen_bytes
    assign d_bytes[b] = d_i[b*8 +: 8];
  end

  // An all-ones mask would leave nothing to emit, so it behaves like all lanes enabled.
  always_comb begin
    en = (&cfg_q) ? '1 : ~cfg_q;
    n  = 0;
    for (int j = 0; j < OUTPUT; j++) begin
      if (en[j]) n = n + 1;
    end
  end

  // rdy_o depends only on registered state so the producer never sees a path from ack_i.
  assign rdy_o = alive_q && (cnt_q <= CW'(OUTPUT - 1));
  assign push  = stb_i && rdy_o;
  assign stb_o = (state_q == FULL);
  assign q_o   = q_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cfg_d   = cfg_q;
    q_d     = q_q;
    buf_d   = buf_q;
    load    = 1'b0;
    cnt     = int'(cnt_q);
    pop     = 0;
    avail   = 0;
    k       = 0;
    idx     = 0;

    if (cfg_stb_i) begin
      cfg_d   = cfg_i;
      cnt_d   = '0;
      state_d = EMPTY;
      for (int i = 0; i < BUF; i++) buf_d[i] = 8'h00;
    end else begin
      if ((state_q == EMPTY || ack_i) && cnt >= n) begin
        load    = 1'b1;
        avail   = n;
        pop     = n;
        state_d = FULL;
      end else if (state_q == FULL && ack_i) begin
        state_d = EMPTY;
      end
`ifdef UNCACHE_FLUSH_EN
      else if (state_q == EMPTY && flush_i && cnt > 0) begin
        load    = 1'b1;
        avail   = cnt;
        pop     = cnt;
        state_d = FULL;
      end
`endif

      if (load) begin
        for (int j = 0; j < OUTPUT; j++) begin
          q_d[j*8 +: 8] = 8'h00;
          if (en[j]) begin
            if (k < avail) q_d[j*8 +: 8] = buf_q[BW'(k)];
            k = k + 1;
          end
        end
      end

      // Compact the survivors of the pop to the front, then append the new word behind them.
      for (int i = 0; i < BUF; i++) begin
        idx = i + pop;
        if (idx < cnt)
          buf_d[i] = buf_q[BW'(idx)];
        else if (push && (idx - cnt) < INPUT)
          buf_d[i] = d_bytes[DW'(idx - cnt)];
        else
          buf_d[i] = 8'h00;
      end
      cnt_d = CW'(cnt + (push ? INPUT : 0) - pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= EMPTY;
      cnt_q   <= '0;
      cfg_q   <= '0;
      q_q     <= '0;
      alive_q <= 1'b0;
      for (int i = 0; i < BUF; i++) buf_q[i] <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cfg_q   <= cfg_d;
      q_q     <= q_d;
      buf_q   <= buf_d;
      alive_q <= 1'b1;
    end
  end

endmodule
